// File: rtl/gray_pkg.sv
// gray_pkg
// Shared helpers for Gray-coded pointer crossing.
//   bin2gray_f / gray2bin_f : pure combinational encode/decode. They operate on
//                             a MAX_WIDTH-wide vector. Callers zero-extend a
//                             narrower pointer into it and truncate the result.
//                             Zero upper bits do not disturb either transform.
//   MIN_SYNC_STAGES         : smallest synchronizer depth ever built.
package gray_pkg;

  localparam int MAX_WIDTH       = 64;
  localparam int MIN_SYNC_STAGES = 2;

  function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Decode from the MSB down. Each binary bit is the XOR of all Gray bits at or
  // above it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin_f(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin = '0;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// gray_sync_chain
// Multi-flop synchronizer for a Gray-coded bus. It is a plain register chain
// with no logic between the flops. Depth is max(STAGES, MIN_SYNC_STAGES).
// Ports:
//   clk   : destination clock (rising edge)
//   rst_n : asynchronous active-low reset; every stage is loaded with INITIAL_VAL
//   d     : asynchronous Gray input
//   q     : output of the last stage
module gray_sync_chain
  import gray_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] INITIAL_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int NUM_STAGES = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [WIDTH-1:0] stage_q [NUM_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= INITIAL_VAL;
      end
    end else begin
      stage_q[0] <= d;
      for (int k = 1; k < NUM_STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
// Pointer-crossing endpoint. It holds a local binary pointer and exports it as
// a registered Gray code. It also synchronizes a foreign Gray pointer, decodes
// it, and reports the modular difference between the two pointers.
// Ports:
//   clk              : sole clock, rising edge
//   rst_n            : asynchronous active-low reset
//   inc              : increment local pointer at this edge
//   local_bin        : local pointer, binary
//   local_gray       : local pointer, Gray, straight from a flop (safe to export)
//   remote_gray      : foreign-domain Gray pointer, asynchronous to clk
//   remote_gray_sync : remote_gray after the synchronizer chain
//   remote_bin       : binary decode of remote_gray_sync (combinational)
//   diff             : (local_bin - remote_bin) mod 2^WIDTH (combinational)
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] INITIAL_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] local_bin,
  output logic [WIDTH-1:0] local_gray,
  input  logic [WIDTH-1:0] remote_gray,
  output logic [WIDTH-1:0] remote_gray_sync,
  output logic [WIDTH-1:0] remote_bin,
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH-1:0] local_bin_q;
  logic [WIDTH-1:0] local_gray_q;
  logic [WIDTH-1:0] next_bin;

  assign next_bin = local_bin_q + WIDTH'(1);

  // Gray is computed from the incremented value and registered alongside the
  // binary count. This keeps local_gray a single flop output with no glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      local_bin_q  <= '0;
      local_gray_q <= '0;
    end else if (inc) begin
      local_bin_q  <= next_bin;
      local_gray_q <= WIDTH'(bin2gray_f(MAX_WIDTH'(next_bin)));
    end
  end

  gray_sync_chain #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .INITIAL_VAL (INITIAL_VAL)
  ) u_remote_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (remote_gray),
    .q     (remote_gray_sync)
  );

  assign remote_bin = WIDTH'(gray2bin_f(MAX_WIDTH'(remote_gray_sync)));
  assign local_bin  = local_bin_q;
  assign local_gray = local_gray_q;
  assign diff       = local_bin_q - remote_bin;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync
// Directed bench for gray_ptr_sync with WIDTH=4, STAGES=2, INITIAL_VAL=0.
// The reference model tracks the local count as an integer. It keeps the
// remote samples in a queue and derives expected outputs arithmetically. It
// decodes Gray by searching for the binary value whose code matches.
module tb_gray_ptr_sync;

  localparam int W      = 4;
  localparam int STAGES = 2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic         inc;
  logic [W-1:0] remote_gray;
  logic [W-1:0] local_bin;
  logic [W-1:0] local_gray;
  logic [W-1:0] remote_gray_sync;
  logic [W-1:0] remote_bin;
  logic [W-1:0] diff;

  gray_ptr_sync #(
    .WIDTH       (W),
    .STAGES      (STAGES),
    .INITIAL_VAL ('0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inc              (inc),
    .local_bin        (local_bin),
    .local_gray       (local_gray),
    .remote_gray      (remote_gray),
    .remote_gray_sync (remote_gray_sync),
    .remote_bin       (remote_bin),
    .diff             (diff)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%h) expected %0d (0x%h)", name, $time, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           model_cnt = 0;
  logic [W-1:0] exp_q[$] = '{4'd0, 4'd0};  // oldest sample first

  function automatic int gray_code(input int b);
    return (b ^ (b >> 1)) % (1 << W);
  endfunction

  function automatic int decode_search(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (gray_code(b) == int'(g)) return b;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt = 0;
      exp_q = '{4'd0, 4'd0};
    end else begin
      if (inc) model_cnt = (model_cnt + 1) % (1 << W);
      void'(exp_q.pop_front());
      exp_q.push_back(remote_gray);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      int rb;
      rb = decode_search(exp_q[0]);
      chk("model_local_bin",  local_bin,        W'(model_cnt));
      chk("model_local_gray", local_gray,       W'(gray_code(model_cnt)));
      chk("model_sync",       remote_gray_sync, exp_q[0]);
      chk("model_remote_bin", remote_bin,       W'(rb));
      chk("model_diff",       diff,             W'((model_cnt - rb + (1 << W)) % (1 << W)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_local_bin"},  local_bin,        4'd0);
    chk({tag, "_local_gray"}, local_gray,       4'd0);
    chk({tag, "_sync"},       remote_gray_sync, 4'd0);
    chk({tag, "_remote_bin"}, remote_bin,       4'd0);
    chk({tag, "_diff"},       diff,             4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    inc         = 1'b0;
    remote_gray = 4'd0;

    // Reset with the clock stopped
    #1;
    all_zero("reset");

    // Release reset, start clock
    #1 rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    check_en = 1'b1;

    // Count 5, then hold
    inc = 1'b1;
    tick(5);
    chk("count_bin",  local_bin,  4'd5);
    chk("count_gray", local_gray, 4'b0111);
    inc = 1'b0;
    tick(3);
    chk("hold_bin",  local_bin,  4'd5);
    chk("hold_gray", local_gray, 4'b0111);

    // Synchronizer latency
    remote_gray = 4'b1000;
    tick(1);
    chk("lat_edge1", remote_gray_sync, 4'b0000);
    tick(1);
    chk("lat_edge2", remote_gray_sync, 4'b1000);
    chk("lat_bin",   remote_bin,       4'd15);
    chk("lat_diff",  diff,             4'd6);

    // Wrap of the local pointer
    inc = 1'b1;
    tick(10);
    chk("pre_wrap_bin",  local_bin,  4'd15);
    chk("pre_wrap_gray", local_gray, 4'b1000);
    tick(1);
    chk("wrap_bin",  local_bin,  4'd0);
    chk("wrap_gray", local_gray, 4'b0000);
    tick(3);
    inc = 1'b0;
    chk("diff_local", local_bin, 4'd3);
    remote_gray = 4'b1001;
    tick(2);
    chk("diff_remote_bin", remote_bin, 4'd14);
    chk("diff_wrap",       diff,       4'd5);

    // Decode sweep along the Gray sequence
    for (int b = 0; b < 16; b++) begin
      logic [W-1:0] bv;
      bv = W'(b);
      remote_gray = bv ^ (bv >> 1);
      tick(2);
      chk("sweep_bin", remote_bin, bv);
    end

    // Mid-operation reset
    inc = 1'b1;
    tick(6);
    inc = 1'b0;
    remote_gray = 4'b0101;
    tick(2);
    chk("mid_local", local_bin,  4'd9);
    chk("mid_rbin",  remote_bin, 4'd6);
    #2 rst_n = 1'b0;
    remote_gray = 4'd0;
    #1;
    all_zero("mid_reset");
    #1;
    inc   = 1'b1;
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_count", local_bin, 4'd3);
    chk("post_reset_gray",  local_gray, 4'b0010);
    inc = 1'b0;
    tick(2);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
